mem_slave: RTL and testbench

Synchronous single-port memory target that consumes the valid/ready memory-bus transactions issued by the driver side of the memory interface. It accepts one write or read per handshake, inserts a programmable number of wait states, commits writes to an internal array, and returns read data with a single-cycle `ready` pulse. It is the DUT-side responder behind the memory interface, and the passive monitor samples its outputs.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_slave_if.sv | 44 ++++
 rtl/mem_array.sv | 47 ++++
 rtl/mem_slave.sv | 111 +++++++++++
 tb/tb_mem_slave.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the mem_slave memory target: the FSM state
// encoding, the largest supported wait-state count and the width of the
// wait-state counter. Also provides fallback values for the SZ / WIDTH
// macros used as parameter defaults.
// Ports: none (package).
`ifndef SZ
`define SZ 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

package mem_pkg;
   // Largest WAIT_CYCLES value the 4-bit wait counter can express.
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;
endpackage

// File: rtl/mem_slave_if.sv
// mem_slave_if
// Memory bus between a request driver (master) and the mem_slave target.
// Ports (signals):
//   valid             master->slave  request present
//   write_read_enable master->slave  1 = write, 0 = read
//   address           master->slave  word address, SZ bits
//   wr_data           master->slave  write data, WIDTH bits
//   rdata             slave->master  read data, valid while ready=1 on a read
//   ready             slave->master  one-cycle completion pulse
//
// Handshake: a request is taken whenever the slave is idle and samples
// valid=1 at a clock edge. The master keeps valid and all request fields
// stable until it has seen ready=1, and may change them from the following
// cycle on. ready is a completion pulse, not a back-pressure signal: it is
// high for exactly one cycle per accepted request, and keeping valid high
// after ready simply issues the next request.
`ifndef SZ
`define SZ 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

interface mem_slave_if #(
   parameter int SZ    = `SZ,
   parameter int WIDTH = `WIDTH
);
   logic             valid;
   logic             write_read_enable;
   logic [SZ-1:0]    address;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rdata;
   logic             ready;

   modport master (
      output valid, write_read_enable, address, wr_data,
      input  rdata, ready
   );

   modport slave (
      input  valid, write_read_enable, address, wr_data,
      output rdata, ready
   );
endinterface

// File: rtl/mem_array.sv
// mem_array
// 2**SZ x WIDTH storage with a synchronous write port and a registered
// read port. A reset clears every word and the read register; reset wins
// over a write issued in the same cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   we, re     write / read enable for this cycle
//   addr       word address
//   wdata      write data
//   rdata      registered read data (holds until the next read)
`ifndef SZ
`define SZ 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module mem_array #(
   parameter int SZ    = `SZ,
   parameter int WIDTH = `WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic             re,
   input  logic [SZ-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [2**SZ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**SZ; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[addr] <= wdata;
         end
         if (re) begin
            rdata <= mem[addr];
         end
      end
   end
endmodule

// File: rtl/mem_slave.sv
// mem_slave
// Single-port memory target. Accepts one read or write per request,
// inserts WAIT_CYCLES idle cycles, then executes the latched request and
// pulses ready for one cycle. Outputs are registered.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        mem_slave_if slave modport (valid, write_read_enable,
//              address, wr_data in; rdata, ready out)
//   state      current FSM state, for observation
`ifndef SZ
`define SZ 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module mem_slave
   import mem_pkg::*;
#(
   parameter int SZ          = `SZ,
   parameter int WIDTH       = `WIDTH,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   mem_slave_if.slave  bus,
   output mem_state_e  state
);
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("mem_slave: WAIT_CYCLES out of range 0..15");
   end

   // Counter value loaded on acceptance; WAIT leaves when it reaches zero,
   // which gives exactly WAIT_CYCLES cycles in WAIT.
   localparam logic [CNT_W-1:0] CNT_LOAD =
      CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   mem_state_e       state_q;
   logic [SZ-1:0]    addr_q;
   logic [WIDTH-1:0] data_q;
   logic             wr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             exec_we;
   logic             exec_re;
   logic [WIDTH-1:0] rdata_w;

   // The operation runs on the edge that leaves RESP, which is the same
   // edge that raises ready, so rdata and ready become visible together.
   assign exec_we = (state_q == RESP) &&  wr_q;
   assign exec_re = (state_q == RESP) && !wr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.valid) begin
                  addr_q <= bus.address;
                  data_q <= bus.wr_data;
                  wr_q   <= bus.write_read_enable;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                  end else begin
                     cnt_q   <= CNT_LOAD;
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset is handled inside the array as well, so a write whose execute
   // edge coincides with rst is never committed.
   mem_array #(
      .SZ    (SZ),
      .WIDTH (WIDTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (exec_we),
      .re    (exec_re),
      .addr  (addr_q),
      .wdata (data_q),
      .rdata (rdata_w)
   );

   assign bus.ready = ready_q;
   assign bus.rdata = rdata_w;
   assign state     = state_q;
endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave
// Three mem_slave instances (WAIT_CYCLES = 0, 3, 2) exercised one at a
// time. The driver pushes the expected rdata and response cycle for each
// request; a negedge monitor pops and compares on every ready pulse.
module tb_mem_slave;
   import mem_pkg::*;

   localparam int SZ    = 4;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst0, rst3, rst2;
   int   cyc = 0;
   mem_state_e st0, st3, st2;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0]       id;
      logic [WIDTH-1:0] data;
      logic [31:0]      cycle;
   } exp_t;

   exp_t exp_q[$];

   mem_slave_if #(.SZ(SZ), .WIDTH(WIDTH)) bus0 ();
   mem_slave_if #(.SZ(SZ), .WIDTH(WIDTH)) bus3 ();
   mem_slave_if #(.SZ(SZ), .WIDTH(WIDTH)) bus2 ();

   mem_slave #(.SZ(SZ), .WIDTH(WIDTH), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst0), .bus(bus0), .state(st0));
   mem_slave #(.SZ(SZ), .WIDTH(WIDTH), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst3), .bus(bus3), .state(st3));
   mem_slave #(.SZ(SZ), .WIDTH(WIDTH), .WAIT_CYCLES(2)) u2 (
      .clk(clk), .rst(rst2), .bus(bus2), .state(st2));

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int wait_of(input int id);
      case (id)
         0:       return 0;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   task automatic drive(input int id, input logic v, input logic wr,
                        input logic [SZ-1:0] a, input logic [WIDTH-1:0] d);
      case (id)
         0: begin bus0.valid = v; bus0.write_read_enable = wr; bus0.address = a; bus0.wr_data = d; end
         1: begin bus3.valid = v; bus3.write_read_enable = wr; bus3.address = a; bus3.wr_data = d; end
         default: begin bus2.valid = v; bus2.write_read_enable = wr; bus2.address = a; bus2.wr_data = d; end
      endcase
   endtask

   task automatic drop_valid(input int id);
      case (id)
         0:       bus0.valid = 1'b0;
         1:       bus3.valid = 1'b0;
         default: bus2.valid = 1'b0;
      endcase
   endtask

   // Issue one request at a negedge. Returns at the negedge where its
   // ready pulse is visible, so a following call can present the next
   // request immediately (back-to-back when hold=1).
   // scramble: after acceptance, put a garbage write on the bus.
   task automatic txn(input int id, input logic wr, input logic [SZ-1:0] a,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_rd,
                      input bit hold, input bit scramble);
      exp_t e;
      drive(id, 1'b1, wr, a, d);
      e.id    = id[1:0];
      e.data  = exp_rd;
      e.cycle = 32'(cyc + 2 + wait_of(id));
      exp_q.push_back(e);
      @(negedge clk);
      if (scramble) begin
         drive(id, 1'b0, 1'b1, a ^ 4'h1, 8'hFF);
      end else if (!hold) begin
         drop_valid(id);
      end
      repeat (wait_of(id) + 1) @(negedge clk);
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic mon(input logic [1:0] id, input logic rdy, input logic [WIDTH-1:0] rd);
      exp_t e;
      if (rdy === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready inst=%0d rdata=%0h expected no response (cycle %0d)",
                     id, rd, cyc);
         end else begin
            e = exp_q.pop_front();
            check("resp_inst",  32'(id),  32'(e.id));
            check("resp_rdata", 32'(rd),  32'(e.data));
            check("resp_cycle", 32'(cyc), e.cycle);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(2'd0, bus0.ready, bus0.rdata);
      mon(2'd1, bus3.ready, bus3.rdata);
      mon(2'd2, bus2.ready, bus2.rdata);
   end

   // ---------------- stimulus ----------------
   initial begin
      rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      drive(2, 1'b0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;

      check("reset_ready0", 32'(bus0.ready), 32'd0);
      check("reset_rdata0", 32'(bus0.rdata), 32'd0);
      check("reset_state0", 32'(st0), 32'(IDLE));
      check("reset_ready3", 32'(bus3.ready), 32'd0);
      check("reset_rdata3", 32'(bus3.rdata), 32'd0);
      check("reset_state3", 32'(st3), 32'(IDLE));
      check("reset_ready2", 32'(bus2.ready), 32'd0);
      check("reset_rdata2", 32'(bus2.rdata), 32'd0);
      check("reset_state2", 32'(st2), 32'(IDLE));

      // WAIT_CYCLES=0: read after reset, write/read, rdata hold across a write
      txn(0, 1'b0, 4'h3, 8'h00, 8'h00, 0, 0);
      txn(0, 1'b1, 4'h7, 8'hA5, 8'h00, 0, 0);
      txn(0, 1'b0, 4'h7, 8'h00, 8'hA5, 0, 0);
      txn(0, 1'b1, 4'h7, 8'h3C, 8'hA5, 0, 0);
      txn(0, 1'b0, 4'h7, 8'h00, 8'h3C, 0, 0);

      // Back-to-back with valid held high, including top address 0xF
      txn(0, 1'b1, 4'h0, 8'h11, 8'h3C, 1, 0);
      txn(0, 1'b1, 4'hF, 8'h22, 8'h3C, 1, 0);
      txn(0, 1'b0, 4'h0, 8'h00, 8'h11, 1, 0);
      txn(0, 1'b0, 4'hF, 8'h00, 8'h22, 0, 0);
      repeat (2) @(negedge clk);

      // WAIT_CYCLES=3: bus changes during WAIT must not affect the result
      txn(1, 1'b1, 4'h5, 8'h77, 8'h00, 0, 0);
      txn(1, 1'b0, 4'h5, 8'h00, 8'h77, 0, 1);
      txn(1, 1'b0, 4'h4, 8'h00, 8'h00, 0, 0);
      repeat (2) @(negedge clk);

      // WAIT_CYCLES=2: reset during WAIT drops the write with no response
      drive(2, 1'b1, 1'b1, 4'h2, 8'h5A);
      @(negedge clk);
      drop_valid(2);
      @(negedge clk);
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      check("midreset_state", 32'(st2), 32'(IDLE));
      repeat (5) @(negedge clk);
      txn(2, 1'b0, 4'h2, 8'h00, 8'h00, 0, 0);

      // Reset on the very edge that would commit the write
      drive(2, 1'b1, 1'b1, 4'h2, 8'h5A);
      @(negedge clk);
      drop_valid(2);
      repeat (2) @(negedge clk);
      check("resp_state_before_rst", 32'(st2), 32'(RESP));
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      check("resp_rst_ready", 32'(bus2.ready), 32'd0);
      repeat (3) @(negedge clk);
      txn(2, 1'b0, 4'h2, 8'h00, 8'h00, 0, 0);

      // Positive control on the same instance: write then read back
      txn(2, 1'b1, 4'h2, 8'h5A, 8'h00, 0, 0);
      txn(2, 1'b0, 4'h2, 8'h00, 8'h5A, 0, 0);

      repeat (6) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d expected completion before time limit", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
